writeback_arbiter: RTL and testbench

Merges the X→W result streams of several execute units (ALU, multiplier, memory, …) onto the single writeback port. Each cycle it grants at most one valid unit in round-robin order and captures that unit's result in a one-entry output register. The register presents the result to the writeback stage with a val/rdy handshake. It sits between the execute units' X__W outputs and the W stage, and removes the need for a writeback port per unit.

---
 rtl/writeback_arbiter.sv | 97 +++++++++
 tb/tb_writeback_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin merge of execute-unit results onto one registered writeback port
//   clk, rst (async, active-low)
//   ex_*  : per-unit result streams, unit i in slice i, ex_val/ex_rdy handshake
//   w_*   : one-entry output register, w_val/w_rdy handshake, w_src = producing unit
module writeback_arbiter #(
  parameter int p_num_units      = 4,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6,
  localparam int SW = (p_num_units > 1) ? $clog2(p_num_units) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [p_num_units-1:0]                  ex_val,
  output logic [p_num_units-1:0]                  ex_rdy,
  input  logic [32*p_num_units-1:0]               ex_pc,
  input  logic [p_seq_num_bits*p_num_units-1:0]   ex_seq_num,
  input  logic [5*p_num_units-1:0]                ex_waddr,
  input  logic [32*p_num_units-1:0]               ex_wdata,
  input  logic [p_num_units-1:0]                  ex_wen,
  input  logic [p_phys_addr_bits*p_num_units-1:0] ex_preg,
  input  logic [p_phys_addr_bits*p_num_units-1:0] ex_ppreg,
  output logic                                    w_val,
  input  logic                                    w_rdy,
  output logic [31:0]                             w_pc,
  output logic [p_seq_num_bits-1:0]               w_seq_num,
  output logic [4:0]                              w_waddr,
  output logic [31:0]                             w_wdata,
  output logic                                    w_wen,
  output logic [p_phys_addr_bits-1:0]             w_preg,
  output logic [p_phys_addr_bits-1:0]             w_ppreg,
  output logic [SW-1:0]                           w_src
);
  logic [31:0]                 pc_a    [p_num_units];
  logic [p_seq_num_bits-1:0]   seq_a   [p_num_units];
  logic [4:0]                  waddr_a [p_num_units];
  logic [31:0]                 wdata_a [p_num_units];
  logic [p_phys_addr_bits-1:0] preg_a  [p_num_units];
  logic [p_phys_addr_bits-1:0] ppreg_a [p_num_units];
  for (genvar i = 0; i < p_num_units; i++) begin : g_unpack
    assign pc_a[i]    = ex_pc[i*32 +: 32];
    assign seq_a[i]   = ex_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
    assign waddr_a[i] = ex_waddr[i*5 +: 5];
    assign wdata_a[i] = ex_wdata[i*32 +: 32];
    assign preg_a[i]  = ex_preg[i*p_phys_addr_bits +: p_phys_addr_bits];
    assign ppreg_a[i] = ex_ppreg[i*p_phys_addr_bits +: p_phys_addr_bits];
  end
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] gnt_idx;
  logic          found;
  logic          gnt;
  logic [SW-1:0] rr_next;
  // Scan rr_ptr, rr_ptr+1, ... with an explicit modulo wrap so non-power-of-two unit counts work.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < p_num_units; k++) begin
      int s;
      s = int'(rr_ptr) + k;
      if (s >= p_num_units) s = s - p_num_units;
      if (!found && ex_val[SW'(s)]) begin
        found   = 1'b1;
        gnt_idx = SW'(s);
      end
    end
  end
  // A draining result frees the slot in the same cycle; reset suppresses any grant.
  assign gnt     = rst & found & (!w_val | w_rdy);
  assign ex_rdy  = gnt ? ({{(p_num_units-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign rr_next = (gnt_idx == SW'(p_num_units - 1)) ? '0 : gnt_idx + 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      w_val     <= 1'b0;
      w_src     <= '0;
      w_pc      <= '0;
      w_seq_num <= '0;
      w_waddr   <= '0;
      w_wdata   <= '0;
      w_wen     <= 1'b0;
      w_preg    <= '0;
      w_ppreg   <= '0;
    end else if (gnt) begin
      rr_ptr    <= rr_next;
      w_val     <= 1'b1;
      w_src     <= gnt_idx;
      w_pc      <= pc_a[gnt_idx];
      w_seq_num <= seq_a[gnt_idx];
      w_waddr   <= waddr_a[gnt_idx];
      w_wdata   <= wdata_a[gnt_idx];
      w_wen     <= ex_wen[gnt_idx];
      w_preg    <= preg_a[gnt_idx];
      w_ppreg   <= ppreg_a[gnt_idx];
    end else if (w_rdy) begin
      w_val <= 1'b0;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: randomized and directed checks of writeback_arbiter against a transaction-level model
module tb_writeback_arbiter;
  localparam int N = 4;
  localparam int S = 5;
  localparam int P = 6;
  typedef struct packed {
    logic [31:0]  pc;
    logic [S-1:0] seq;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         wen;
    logic [P-1:0] preg;
    logic [P-1:0] ppreg;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0]    ex_val = '0;
  logic [N-1:0]    ex_rdy;
  logic [32*N-1:0] ex_pc = '0;
  logic [S*N-1:0]  ex_seq_num = '0;
  logic [5*N-1:0]  ex_waddr = '0;
  logic [32*N-1:0] ex_wdata = '0;
  logic [N-1:0]    ex_wen = '0;
  logic [P*N-1:0]  ex_preg = '0;
  logic [P*N-1:0]  ex_ppreg = '0;
  logic            w_val;
  logic            w_rdy = 1'b1;
  logic [31:0]     w_pc;
  logic [S-1:0]    w_seq_num;
  logic [4:0]      w_waddr;
  logic [31:0]     w_wdata;
  logic            w_wen;
  logic [P-1:0]    w_preg;
  logic [P-1:0]    w_ppreg;
  logic [1:0]      w_src;
  writeback_arbiter #(.p_num_units(N), .p_seq_num_bits(S), .p_phys_addr_bits(P)) dut (
    .clk(clk), .rst(rst), .ex_val(ex_val), .ex_rdy(ex_rdy), .ex_pc(ex_pc), .ex_seq_num(ex_seq_num),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wen(ex_wen), .ex_preg(ex_preg), .ex_ppreg(ex_ppreg),
    .w_val(w_val), .w_rdy(w_rdy), .w_pc(w_pc), .w_seq_num(w_seq_num), .w_waddr(w_waddr),
    .w_wdata(w_wdata), .w_wen(w_wen), .w_preg(w_preg), .w_ppreg(w_ppreg), .w_src(w_src)
  );
  logic [2:0]     v3 = '0;
  logic [2:0]     rdy3;
  logic [95:0]    pc3 = '0;
  logic [14:0]    seq3 = '0;
  logic [14:0]    waddr3 = '0;
  logic [95:0]    wdata3 = '0;
  logic [2:0]     wen3 = '0;
  logic [17:0]    preg3 = '0;
  logic [17:0]    ppreg3 = '0;
  logic           w_val3;
  logic           w_rdy3 = 1'b1;
  logic [31:0]    w_pc3;
  logic [S-1:0]   w_seq3;
  logic [4:0]     w_waddr3;
  logic [31:0]    w_wdata3;
  logic           w_wen3;
  logic [P-1:0]   w_preg3;
  logic [P-1:0]   w_ppreg3;
  logic [1:0]     w_src3;
  writeback_arbiter #(.p_num_units(3), .p_seq_num_bits(S), .p_phys_addr_bits(P)) dut3 (
    .clk(clk), .rst(rst), .ex_val(v3), .ex_rdy(rdy3), .ex_pc(pc3), .ex_seq_num(seq3),
    .ex_waddr(waddr3), .ex_wdata(wdata3), .ex_wen(wen3), .ex_preg(preg3), .ex_ppreg(ppreg3),
    .w_val(w_val3), .w_rdy(w_rdy3), .w_pc(w_pc3), .w_seq_num(w_seq3), .w_waddr(w_waddr3),
    .w_wdata(w_wdata3), .w_wen(w_wen3), .w_preg(w_preg3), .w_ppreg(w_ppreg3), .w_src(w_src3)
  );
  rec_t         u [N];
  rec_t         m_rec;
  bit           m_held;
  int           m_rr;
  int           m_src;
  int           waitc [N];
  int           last_g;
  logic [N-1:0] obs_rdy;
  logic [N-1:0] rv;
  logic [31:0]  hold_d;
  int           checks;
  int           errors;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic rand_unit(input int i);
    u[i].pc    = $urandom;
    u[i].seq   = S'($urandom);
    u[i].waddr = 5'($urandom);
    u[i].wdata = $urandom;
    u[i].wen   = 1'($urandom);
    u[i].preg  = P'($urandom);
    u[i].ppreg = P'($urandom);
  endtask
  task automatic model_reset();
    m_held = 0;
    m_rr   = 0;
    m_src  = 0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
  endtask
  // Called at a falling edge: drives one cycle, checks it, advances the model past the rising edge.
  task automatic apply(input logic [N-1:0] v, input logic r);
    int g;
    ex_val = v;
    w_rdy  = r;
    for (int i = 0; i < N; i++) begin
      ex_pc[i*32 +: 32]     = u[i].pc;
      ex_seq_num[i*S +: S]  = u[i].seq;
      ex_waddr[i*5 +: 5]    = u[i].waddr;
      ex_wdata[i*32 +: 32]  = u[i].wdata;
      ex_wen[i]             = u[i].wen;
      ex_preg[i*P +: P]     = u[i].preg;
      ex_ppreg[i*P +: P]    = u[i].ppreg;
    end
    #1;
    g = -1;
    if (!m_held || r)
      for (int k = 0; k < N; k++) begin
        int j = (m_rr + k) % N;
        if (g < 0 && v[j]) g = j;
      end
    obs_rdy = ex_rdy;
    chk("ex_rdy", 64'(ex_rdy), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("w_val", 64'(w_val), 64'(m_held));
    if (m_held) begin
      chk("w_pc", 64'(w_pc), 64'(m_rec.pc));
      chk("w_seq_num", 64'(w_seq_num), 64'(m_rec.seq));
      chk("w_waddr", 64'(w_waddr), 64'(m_rec.waddr));
      chk("w_wdata", 64'(w_wdata), 64'(m_rec.wdata));
      chk("w_wen", 64'(w_wen), 64'(m_rec.wen));
      chk("w_preg", 64'(w_preg), 64'(m_rec.preg));
      chk("w_ppreg", 64'(w_ppreg), 64'(m_rec.ppreg));
      chk("w_src", 64'(w_src), 64'(m_src));
    end
    if (g >= 0) chk("fair_wait", 64'(waitc[g] < N), 64'd1);
    for (int i = 0; i < N; i++)
      if (!v[i] || i == g) waitc[i] = 0;
      else if (g >= 0) waitc[i]++;
    if (m_held && r) m_held = 0;
    if (g >= 0) begin
      m_held = 1;
      m_rec  = u[g];
      m_src  = g;
      m_rr   = (g + 1) % N;
    end
    last_g = g;
    @(negedge clk);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    last_g = -1;
    rv     = '0;
    model_reset();
    for (int i = 0; i < N; i++) rand_unit(i);
    ex_val = '1;
    v3     = '1;
    #12;
    chk("rst_w_val", 64'(w_val), 64'd0);
    chk("rst_w_src", 64'(w_src), 64'd0);
    chk("rst_w_wdata", 64'(w_wdata), 64'd0);
    chk("rst_w_pc", 64'(w_pc), 64'd0);
    chk("rst_ex_rdy", 64'(ex_rdy), 64'd0);
    chk("rst_ex_rdy3", 64'(rdy3), 64'd0);
    ex_val = '0;
    v3     = '0;
    @(negedge clk);
    rst = 1'b1;
    v3 = 3'b010;
    #1 chk("np2_g1", 64'(rdy3), 64'b010);
    @(negedge clk);
    v3 = 3'b011;
    #1 chk("np2_wrap_g0", 64'(rdy3), 64'b001);
    @(negedge clk);
    v3 = 3'b010;
    #1 chk("np2_g1b", 64'(rdy3), 64'b010);
    chk("np2_src0", 64'(w_src3), 64'd0);
    @(negedge clk);
    v3 = 3'b100;
    #1 chk("np2_ptr2", 64'(rdy3), 64'b100);
    chk("np2_src1", 64'(w_src3), 64'd1);
    @(negedge clk);
    v3 = 3'b111;
    #1 chk("np2_wrap_after2", 64'(rdy3), 64'b001);
    @(negedge clk);
    v3 = 3'b000;
    u[0].wdata = 32'h12345678;
    u[0].seq   = 5'd3;
    apply(4'b0001, 1'b1);
    chk("single_rdy", 64'(obs_rdy), 64'b0001);
    chk("single_w_val", 64'(w_val), 64'd1);
    chk("single_wdata", 64'(w_wdata), 64'h12345678);
    chk("single_seq", 64'(w_seq_num), 64'd3);
    chk("single_src", 64'(w_src), 64'd0);
    apply(4'b0000, 1'b1);
    chk("single_drain", 64'(w_val), 64'd0);
    apply(4'b1000, 1'b1);
    hold_d = w_wdata;
    for (int c = 0; c < 3; c++) begin
      apply(4'b0110, 1'b0);
      chk("bp_rdy", 64'(obs_rdy), 64'd0);
      chk("bp_stable", 64'(w_wdata), 64'(hold_d));
    end
    apply(4'b0110, 1'b1);
    chk("bp_release_g1", 64'(obs_rdy), 64'b0010);
    apply(4'b0100, 1'b1);
    chk("bp_next_g2", 64'(obs_rdy), 64'b0100);
    apply(4'b0010, 1'b1);
    ex_val = 4'b1111;
    w_rdy  = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_rst_w_val", 64'(w_val), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_w_val", 64'(w_val), 64'd0);
    chk("mid_rst_ex_rdy", 64'(ex_rdy), 64'd0);
    chk("mid_rst_w_src", 64'(w_src), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      apply(4'b1111, 1'b1);
      chk("rr_order", 64'(obs_rdy), 64'd1 << (c % N));
    end
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!(rv[i] && last_g != i)) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          if (rv[i]) rand_unit(i);
        end
      apply(rv, $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 3; c++) apply(4'b0000, 1'b1);
    chk("final_empty", 64'(w_val), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
